// File: rtl/load_store_unit_pkg.sv
// Shared state encodings, funct3 codes and access helpers for the load/store unit.
// Pure declarations and combinational functions; no latency.
// No flow control of its own.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_LOAD_WAIT = 2'd1,
        LSU_RELEASE   = 2'd2
    } lsu_state_t;

    // Byte distance between consecutive MMIO channels.
    localparam int MMIO_STRIDE = 4;

    localparam logic [2:0] SUBFUN3_B  = 3'b000;
    localparam logic [2:0] SUBFUN3_H  = 3'b001;
    localparam logic [2:0] SUBFUN3_W  = 3'b010;
    localparam logic [2:0] SUBFUN3_BU = 3'b100;
    localparam logic [2:0] SUBFUN3_HU = 3'b101;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == SUBFUN3_B) || (f3 == SUBFUN3_H) || (f3 == SUBFUN3_W) ||
               (f3 == SUBFUN3_BU) || (f3 == SUBFUN3_HU);
    endfunction

    // Stores have no unsigned variants.
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == SUBFUN3_B) || (f3 == SUBFUN3_H) || (f3 == SUBFUN3_W);
    endfunction

    // Width is carried in f3[1:0]; bytes can never misalign.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            SUBFUN3_B:  return {{24{s[7]}}, s[7:0]};
            SUBFUN3_BU: return {24'b0, s[7:0]};
            SUBFUN3_H:  return {{16{s[15]}}, s[15:0]};
            SUBFUN3_HU: return {16'b0, s[15:0]};
            default:    return s;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_byte_enable_memory.sv
// Data block memory built from four 8-bit lanes with per-lane write enables.
// Read data valid READ_LATENCY cycles after the read-enable edge; writes land at the edge.
// No backpressure: accepts one read or write per cycle.
module byte_enable_memory #(
    parameter int ADDRESS_SIZE            = 10,
    parameter int READ_LATENCY            = 1,
    parameter     INITIALIZATION_LOCATION = "program/data.hex"
) (
    input  logic                    clk_i,
    input  logic [3:0]              wr_en_i,
    input  logic [31:0]             wr_dat_i,
    input  logic                    rd_en_i,
    input  logic [ADDRESS_SIZE-1:0] addr_i,
    output logic [31:0]             rd_dat_o
);
    localparam int DEPTH = 1 << ADDRESS_SIZE;

    logic [31:0] first_stage;

    // Initial contents come from INITIALIZATION_LOCATION through the implementation
    // flow's memory-preload mechanism; nothing here depends on the image.
    if ($bits(INITIALIZATION_LOCATION) == 0) begin : g_no_image
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_q [DEPTH];
        logic [7:0] lane_rd_q;

        // Lane write, gated by its own byte enable
        always_ff @(posedge clk_i) begin
            if (wr_en_i[l]) lane_q[addr_i] <= wr_dat_i[8*l +: 8];
        end

        // Registered lane read forms the first read pipeline stage
        always_ff @(posedge clk_i) begin
            if (rd_en_i) lane_rd_q <= lane_q[addr_i];
        end

        assign first_stage[8*l +: 8] = lane_rd_q;
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_dat_o = first_stage;
    end else begin : g_latn
        logic [31:0] pipe_q [READ_LATENCY-1];

        // Remaining output pipeline stages
        always_ff @(posedge clk_i) begin
            pipe_q[0] <= first_stage;
            for (int i = 1; i < READ_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end

        assign rd_dat_o = pipe_q[READ_LATENCY-2];
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-enabled data memory plus 8-bit MMIO output registers.
// Stores complete in the issue cycle; loads stall READ_LATENCY cycles (1 for MMIO) then release.
// Holds the pipeline via registered clk_stall while a load is outstanding.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          ADDRESS_SIZE            = 10,
    parameter int          READ_LATENCY            = 1,
    parameter int          MMIO_CHANNELS           = 2,
    parameter logic [31:0] MMIO_BASE               = 32'h2000,
    parameter              INITIALIZATION_LOCATION = "program/data.hex"
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 subfunction_3,
    input  logic [31:0]                input_register1_value,
    input  logic [31:0]                input_register2_value,
    input  logic [31:0]                immediate,
    input  logic                       opcode_is_load,
    input  logic                       opcode_is_store,
    output logic                       clk_stall,
    output logic                       load_error,
    output logic                       store_error,
    output logic [31:0]                result_to_write_rd,
    output logic [8*MMIO_CHANNELS-1:0] memory_mapped_io,
    output logic [MMIO_CHANNELS-1:0]   mmio_write_strobe
);
    localparam int IDX_W = (MMIO_CHANNELS > 1) ? $clog2(MMIO_CHANNELS) : 1;

    lsu_state_t               state_q;
    logic                     clk_stall_q;
    logic [31:0]              result_q;
    logic [7:0]               mmio_q [MMIO_CHANNELS];
    logic [MMIO_CHANNELS-1:0] strobe_q;
    logic [2:0]               count_q;
    logic [2:0]               f3_q;
    logic [1:0]               off_q;
    logic                     mmio_hit_q;
    logic [IDX_W-1:0]         mmio_idx_q;

    logic [31:0]      ea;
    logic             mmio_hit;
    logic [IDX_W-1:0] mmio_idx;
    logic             load_bad, store_bad, load_go, store_go;
    logic [31:0]      mem_rd_dat;

    assign ea = input_register1_value + immediate;

    // Match the effective word address against every channel's word address
    always_comb begin
        logic [31:0] chan_addr;
        mmio_hit = 1'b0;
        mmio_idx = '0;
        for (int n = 0; n < MMIO_CHANNELS; n++) begin
            chan_addr = MMIO_BASE + 32'(MMIO_STRIDE * n);
            if (ea[31:2] == chan_addr[31:2]) begin
                mmio_hit = 1'b1;
                mmio_idx = IDX_W'(n);
            end
        end
    end

    assign load_bad    = !load_f3_ok(subfunction_3) || misaligned(subfunction_3, ea[1:0]);
    assign store_bad   = !store_f3_ok(subfunction_3) || misaligned(subfunction_3, ea[1:0]);
    assign load_error  = opcode_is_load && load_bad;
    assign store_error = opcode_is_store && store_bad;

    // A simultaneous load wins; the store is dropped.
    assign load_go  = (state_q == LSU_IDLE) && opcode_is_load && !load_bad;
    assign store_go = (state_q == LSU_IDLE) && opcode_is_store && !opcode_is_load && !store_bad;

    byte_enable_memory #(
        .ADDRESS_SIZE            (ADDRESS_SIZE),
        .READ_LATENCY            (READ_LATENCY),
        .INITIALIZATION_LOCATION (INITIALIZATION_LOCATION)
    ) u_mem (
        .clk_i    (clk),
        .wr_en_i  ((store_go && !mmio_hit) ? byte_enables(subfunction_3, ea[1:0]) : 4'b0000),
        .wr_dat_i (lane_data(subfunction_3, input_register2_value)),
        .rd_en_i  (load_go && !mmio_hit),
        .addr_i   (ea[ADDRESS_SIZE+1:2]),
        .rd_dat_o (mem_rd_dat)
    );

    // Load sequencing FSM with registered stall, result and MMIO outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LSU_IDLE;
            clk_stall_q <= 1'b0;
            result_q    <= '0;
            strobe_q    <= '0;
            count_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            mmio_hit_q  <= 1'b0;
            mmio_idx_q  <= '0;
            for (int n = 0; n < MMIO_CHANNELS; n++) mmio_q[n] <= '0;
        end else begin
            strobe_q <= '0;
            case (state_q)
                LSU_IDLE: begin
                    if (load_go) begin
                        f3_q        <= subfunction_3;
                        off_q       <= ea[1:0];
                        mmio_hit_q  <= mmio_hit;
                        mmio_idx_q  <= mmio_idx;
                        clk_stall_q <= 1'b1;
                        count_q     <= mmio_hit ? 3'd1 : 3'(READ_LATENCY);
                        state_q     <= LSU_LOAD_WAIT;
                    end else if (store_go && mmio_hit) begin
                        mmio_q[mmio_idx]   <= input_register2_value[7:0];
                        strobe_q[mmio_idx] <= 1'b1;
                    end
                end
                LSU_LOAD_WAIT: begin
                    if (count_q == 3'd1) begin
                        result_q    <= mmio_hit_q ? {24'b0, mmio_q[mmio_idx_q]}
                                                  : format_load(f3_q, off_q, mem_rd_dat);
                        clk_stall_q <= 1'b0;
                        count_q     <= '0;
                        state_q     <= LSU_RELEASE;
                    end else begin
                        count_q <= count_q - 3'd1;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    for (genvar n = 0; n < MMIO_CHANNELS; n++) begin : g_mmio_out
        assign memory_mapped_io[8*n +: 8] = mmio_q[n];
    end

    assign clk_stall          = clk_stall_q;
    assign result_to_write_rd = result_q;
    assign mmio_write_strobe  = strobe_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised data-memory load/store unit for the single-issue core; replaces the read-modify-write data RAM path.
- Per-byte write enables make stores complete with zero stall cycles.
- Loads honour byte offset and a configurable block-memory read latency.
- Provides MMIO_CHANNELS read/write 8-bit memory-mapped output registers with write strobes.

Parameters:
- ADDRESS_SIZE, 10: word-address bits of the data block memory (4*2^ADDRESS_SIZE bytes).
- READ_LATENCY, 1: cycles from read issue to valid read data; legal range 1..4.
- MMIO_CHANNELS, 2: number of 8-bit MMIO registers; legal range 1..8.
- MMIO_BASE, 32'h2000: byte address of channel 0; channel n sits at MMIO_BASE+4n.
- INITIALIZATION_LOCATION, "program/data.hex": memory init file.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- subfunction_3  in  3  funct3 of the current load/store
- input_register1_value  in  32  rs1 (base address)
- input_register2_value  in  32  rs2 (store data)
- immediate  in  32  sign-extended offset
- opcode_is_load  in  1  current instruction is a load
- opcode_is_store  in  1  current instruction is a store
- clk_stall  out  1  registered; high = hold the pipeline
- load_error  out  1  combinational; misaligned or undecodable load
- store_error  out  1  combinational; misaligned or undecodable store
- result_to_write_rd  out  32  registered formatted load result
- memory_mapped_io  out  8*MMIO_CHANNELS  channel n occupies bits [8n+7:8n]
- mmio_write_strobe  out  MMIO_CHANNELS  one-cycle pulse on channel write

Behaviour:
- Reset (asynchronous): state IDLE, clk_stall 0, result_to_write_rd 0, memory_mapped_io 0, mmio_write_strobe 0, latency counter 0. Memory contents are not reset. Reset during a load abandons it; clk_stall drops immediately.
- Effective address: ea = rs1 + immediate, modulo 2^32.
- MMIO hit: ea[31:2] equals channel n's word address for some n < MMIO_CHANNELS. An MMIO hit overrides memory.
- Memory word index: ea[ADDRESS_SIZE+1:2]; upper bits are ignored, so addresses wrap.
- Errors:
  - Byte accesses never misalign. Halfword accesses require ea[0]=0. Word accesses require ea[1:0]=0.
  - An undefined funct3 is a decode error.
  - load_error is gated by opcode_is_load; store_error is gated by opcode_is_store.
  - An errored request performs no access, no stall and no MMIO change.
- Simultaneous opcode_is_load and opcode_is_store: the load is served and the store is ignored.
- FSM states: IDLE, LOAD_WAIT, RELEASE.
  - IDLE + valid store to memory: write at this edge.
    - Byte enables: SB 4'b0001<<ea[1:0]; SH 4'b0011<<ea[1:0]; SW 4'b1111.
    - Write data lane-replicated: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
    - No stall; stay in IDLE. Back-to-back stores sustain 1 per cycle.
  - IDLE + valid store to MMIO channel n: memory_mapped_io[n] <= rs2[7:0] for any store width; strobe[n] pulses the next cycle; no stall.
  - IDLE + valid load:
    - Issue the read and latch funct3, ea[1:0] and the MMIO hit/index.
    - clk_stall <= 1, counter <= READ_LATENCY (1 for an MMIO hit), go to LOAD_WAIT.
  - LOAD_WAIT: counter decrements each edge. On the edge where counter==1:
    - Capture the formatted result and set clk_stall <= 0; go to RELEASE.
    - clk_stall is high for exactly READ_LATENCY cycles (1 for MMIO).
  - RELEASE: one cycle in which the core advances. opcode inputs are ignored; go to IDLE.
- Load formatting: shift the read word right by 8*offset, then:
  - LB: sign-extend bits [7:0]. LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0]. LHU: zero-extend bits [15:0].
  - LW: whole word.
  - An MMIO load returns {24'b0, channel} for every width.
- result_to_write_rd holds its value until the next load completes.

Decomposition:
- define.vh gains LSU_IDLE/LSU_LOAD_WAIT/LSU_RELEASE state encodings and the MMIO stride constant (4); existing SUBFUN3 codes are reused.
- Sub-module byte_enable_memory:
  - Parameters: ADDRESS_SIZE, READ_LATENCY, INITIALIZATION_LOCATION.
  - Storage: four 8-bit lanes.
  - Write path: per-lane write enable.
  - Read path: READ_LATENCY-deep output pipeline.

Test Plan:
- SW 32'hDEADBEEF to 0x100, then LB/LBU at 0x101/0x103 → 32'hFFFFFFBE, 32'h000000DE; with READ_LATENCY=3, clk_stall high exactly 3 cycles.
- SB 8'h5A to 0x102 over word 32'h11223344 → LW returns 32'h115A3344; store asserts no stall; SB/SB/SW back-to-back all land.
- LH at 0x101 → load_error=1, no stall, result unchanged; undefined funct3 3'b011 on store → store_error=1, memory unchanged.
- SW 32'h1234567F to 0x2004 (MMIO_CHANNELS=2) → bits [15:8]=8'h7F, strobe[1] one-cycle pulse, channel 0 unchanged; LB at 0x2004 → 32'h0000007F after 1 stall cycle.
- Assert reset during LOAD_WAIT → clk_stall 0 without waiting for a clock edge, state IDLE, MMIO 0; next load completes normally.
- Load and store asserted together → load result correct, target store address unchanged; ea 32'h80000100 (ADDRESS_SIZE=10) aliases 0x100.
